cache_victim_writeback: RTL and testbench
=========================================

# cache_victim_writeback

Victim writeback buffer for the L1 caches, sitting between the cache controller and the bus interface. When the replacement policy selects a dirty victim way, the controller hands the whole evicted line to this block in one cycle. The block then drains it to the bus as a sequence of beats under a valid/ready handshake, which frees the cache to proceed with the refill. An optional address-match port lets the controller stall a refill that targets the line still being drained.

## Interface
- NUMWAYS, 4, cache associativity; width of the victim way one-hot.
- PA_BITS, 56, physical address width.
- LINELEN, 256, cache line width in bits.
- BEATLEN, 64, bus beat width in bits; LINELEN must be a multiple of BEATLEN; BEATS = LINELEN/BEATLEN ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- EvictValid  in  1  controller offers an evicted dirty line.
- EvictReady  out  1  buffer empty, so an offered line can be accepted.
- EvictAdr  in  PA_BITS  line address; low log2(LINELEN/8) bits are ignored and treated as 0.
- EvictLine  in  LINELEN  line data; beat 0 is bits [BEATLEN-1:0].
- EvictWay  in  NUMWAYS  one-hot victim way, held for status.
- BusValid  out  1  beat valid.
- BusReady  in  1  bus accepts the beat.
- BusAdr  out  PA_BITS  byte address of the current beat.
- BusData  out  BEATLEN  current beat data.
- BusLast  out  1  current beat is the final beat of the line.
- Busy  out  1  a line is held (state DRAIN).
- DrainWay  out  NUMWAYS  way of the held line; 0 when not Busy.
- SnoopAdr  in  PA_BITS  refill address to check.
- SnoopHit  out  1  SnoopAdr is in the same line as the held line.

## Operation
- FSM has two states, EMPTY and DRAIN. Reset enters EMPTY.
- EMPTY:
  - EvictReady=1.
  - When EvictValid=1, capture EvictAdr (line-aligned), EvictLine and EvictWay, clear the beat counter, and go to DRAIN.
- DRAIN:
  - EvictReady=0 and BusValid=1.
  - BusData is captured-line beat[cnt].
  - BusAdr = line address + cnt*(BEATLEN/8).
  - BusLast = (cnt == BEATS-1).
  - On BusValid&BusReady, increment cnt.
  - If the handshake is on the last beat, go to EMPTY.
- BusValid must never drop while a beat is pending. BusAdr, BusData and BusLast hold stable while BusValid&~BusReady.
- An accept and a drain completion never occur in the same cycle, because EvictReady depends on state only. A new line can be accepted one cycle after the last-beat handshake.
- EvictValid while EvictReady=0 is ignored. The controller must hold its offer until EvictReady.
- The beat counter is log2(BEATS) bits wide and does not wrap within a line, since completion occurs at BEATS-1.
- SnoopHit = Busy & (SnoopAdr[PA_BITS-1:log2(LINELEN/8)] == held line address bits). It is combinational and remains asserted through the cycle of the last-beat handshake.
- Reset during DRAIN aborts the drain. The held line is discarded and no further beats are issued.

## Timing
- Reset values: state EMPTY, EvictReady=1 once reset deasserts, BusValid=0, BusLast=0, Busy=0, DrainWay=0, SnoopHit=0.
- Accept at edge N gives BusValid=1 with beat 0 in cycle N+1. There are no bubbles inside the buffer.
- With BusReady held at 1, a line drains in BEATS cycles. EvictReady returns to 1 in the cycle after the last handshake.
- Minimum accept-to-accept spacing is BEATS+1 cycles.
- BusValid, BusAdr, BusData, BusLast, Busy and DrainWay are functions of registers only. EvictReady is a function of state only. SnoopHit is the only input-to-output combinational path.

## Configuration
- CACHE_VICTIM_SNOOP_EN defined: SnoopAdr comparator present; SnoopHit behaves as specified above.
- CACHE_VICTIM_SNOOP_EN undefined: comparator removed; SnoopHit tied to 0 and SnoopAdr unused. The controller must then stall any refill while Busy=1.

## Test plan
- Reset, then idle: EvictReady=1, BusValid=0, Busy=0, DrainWay=0, SnoopHit=0.
- Accept EvictAdr=0x8000_1234 with EvictLine holding beats 0x11…,0x22…,0x33…,0x44… and EvictWay=4'b0100; BusReady=1. Required response:
  - Four beats in consecutive cycles at 0x8000_1220, 0x8000_1228, 0x8000_1230, 0x8000_1238.
  - BusLast only on the fourth beat.
  - DrainWay=4'b0100 throughout.
  - EvictReady=1 on the next cycle.
- BusReady=0 for 3 cycles on beat 1: BusAdr=0x…1228 and data 0x22… stay stable, and BusValid stays 1.
- Hold EvictValid=1 during DRAIN with a second line: it is not accepted until the cycle after the last beat, then drains normally.
- With CACHE_VICTIM_SNOOP_EN, holding 0x8000_1220:
  - SnoopAdr=0x8000_123F gives SnoopHit=1.
  - SnoopAdr=0x8000_1240 gives SnoopHit=0.
  - With the macro undefined, SnoopHit=0 in both cases.
- Assert reset after beat 1 handshakes: BusValid=0 immediately (asynchronously). After release, EvictReady=1 and no stale beats are issued.

Source files
------------

// File: rtl/cache_victim_writeback.sv
// Victim writeback buffer: takes one dirty line from the cache controller and drains it to the bus beat by beat.
// Optional refill snoop comparator enabled by defining CACHE_VICTIM_SNOOP_EN.
module cache_victim_writeback #(
    parameter int NUMWAYS = 4,
    parameter int PA_BITS = 56,
    parameter int LINELEN = 256,
    parameter int BEATLEN = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               EvictValid,
    output logic               EvictReady,
    input  logic [PA_BITS-1:0] EvictAdr,
    input  logic [LINELEN-1:0] EvictLine,
    input  logic [NUMWAYS-1:0] EvictWay,
    output logic               BusValid,
    input  logic               BusReady,
    output logic [PA_BITS-1:0] BusAdr,
    output logic [BEATLEN-1:0] BusData,
    output logic               BusLast,
    output logic               Busy,
    output logic [NUMWAYS-1:0] DrainWay,
    input  logic [PA_BITS-1:0] SnoopAdr,
    output logic               SnoopHit
);

    localparam int BEATS   = LINELEN / BEATLEN;
    localparam int CNTW    = $clog2(BEATS);
    localparam int BEATOFF = $clog2(BEATLEN / 8);
    localparam int LINEOFF = $clog2(LINELEN / 8);
    localparam int TAGW    = PA_BITS - LINEOFF;
    localparam logic [CNTW-1:0] LASTCNT = CNTW'(BEATS - 1);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state_r;
    state_t             nextState_s;
    logic [TAGW-1:0]    lineTag_r;
    logic [LINELEN-1:0] line_r;
    logic [NUMWAYS-1:0] way_r;
    logic [CNTW-1:0]    cnt_r;
    logic               accept_s;
    logic               beatDone_s;
    logic               lastBeat_s;
    logic               drain_s;

    function automatic logic [BEATLEN-1:0] selectBeat(
        input logic [LINELEN-1:0] line,
        input logic [CNTW-1:0]    idx
    );
        selectBeat = line[int'(idx)*BEATLEN +: BEATLEN];
    endfunction

    assign drain_s    = (state_r == DRAIN);
    assign lastBeat_s = (cnt_r == LASTCNT);

    // Next-state and handshake decode; accept only when empty, so accept and completion never coincide.
    always_comb begin
        nextState_s = state_r;
        accept_s    = 1'b0;
        beatDone_s  = 1'b0;
        case (state_r)
            EMPTY: begin
                if (EvictValid) begin
                    accept_s    = 1'b1;
                    nextState_s = DRAIN;
                end else begin
                    nextState_s = EMPTY;
                end
            end
            DRAIN: begin
                if (BusReady) begin
                    beatDone_s = 1'b1;
                    if (lastBeat_s) begin
                        nextState_s = EMPTY;
                    end else begin
                        nextState_s = DRAIN;
                    end
                end else begin
                    nextState_s = DRAIN;
                end
            end
            default: begin
                nextState_s = EMPTY;
            end
        endcase
    end

    // State register; reset aborts any drain in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= EMPTY;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Held line, way and beat counter; counter returns to zero on the last beat instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lineTag_r <= {TAGW{1'b0}};
            line_r    <= {LINELEN{1'b0}};
            way_r     <= {NUMWAYS{1'b0}};
            cnt_r     <= {CNTW{1'b0}};
        end else if (accept_s) begin
            lineTag_r <= EvictAdr[PA_BITS-1:LINEOFF];
            line_r    <= EvictLine;
            way_r     <= EvictWay;
            cnt_r     <= {CNTW{1'b0}};
        end else if (beatDone_s) begin
            if (lastBeat_s) begin
                cnt_r <= {CNTW{1'b0}};
                way_r <= {NUMWAYS{1'b0}};
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
        end
    end

    assign EvictReady = ~drain_s;
    assign BusValid   = drain_s;
    assign Busy       = drain_s;
    assign BusLast    = drain_s & lastBeat_s;
    assign BusAdr     = drain_s ? {lineTag_r, cnt_r, {BEATOFF{1'b0}}} : {PA_BITS{1'b0}};
    assign BusData    = drain_s ? selectBeat(line_r, cnt_r) : {BEATLEN{1'b0}};
    assign DrainWay   = drain_s ? way_r : {NUMWAYS{1'b0}};

`ifdef CACHE_VICTIM_SNOOP_EN
    // Only the line tag matters; the offset within the line is irrelevant for a refill conflict.
    assign SnoopHit = drain_s & (SnoopAdr[PA_BITS-1:LINEOFF] == lineTag_r);
    logic unusedAdrBits_s;
    assign unusedAdrBits_s = ^{EvictAdr[LINEOFF-1:0], SnoopAdr[LINEOFF-1:0]};
`else
    assign SnoopHit = 1'b0;
    logic unusedAdrBits_s;
    assign unusedAdrBits_s = ^{EvictAdr[LINEOFF-1:0], SnoopAdr};
`endif

endmodule

// File: tb/tb_cache_victim_writeback.sv
// Self-checking bench for cache_victim_writeback: per-cycle vector table plus a beat scoreboard.
module tb_cache_victim_writeback;

`ifdef CACHE_VICTIM_SNOOP_EN
    localparam logic SNOOP_EN = 1'b1;
`else
    localparam logic SNOOP_EN = 1'b0;
`endif

    localparam logic [255:0] LINE_A = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    localparam logic [255:0] LINE_B = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    localparam logic [55:0]  ADR_A  = 56'h0000_0080_001234;
    localparam logic [55:0]  ADR_B  = 56'h0000_00C0_FFE7;

    logic         clk;
    logic         rst_n;
    logic         evictValid;
    logic         evictReady;
    logic [55:0]  evictAdr;
    logic [255:0] evictLine;
    logic [3:0]   evictWay;
    logic         busValid;
    logic         busReady;
    logic [55:0]  busAdr;
    logic [63:0]  busData;
    logic         busLast;
    logic         busy;
    logic [3:0]   drainWay;
    logic [55:0]  snoopAdr;
    logic         snoopHit;

    int checks = 0;
    int failures = 0;
    int beatsSeen = 0;

    typedef struct {
        logic [55:0] adr;
        logic [63:0] data;
        logic        last;
        logic [3:0]  way;
    } beat_t;

    beat_t sbq[$];

    typedef struct {
        logic        ev;
        logic        br;
        logic [55:0] snoop;
        logic        er;
        logic        bv;
        logic        bl;
        logic        bsy;
        logic [55:0] badr;
        logic [63:0] bdata;
        logic [3:0]  dway;
        logic        sh;
    } vec_t;

    vec_t tbl[6];

    cache_victim_writeback dut (
        .clk        (clk),
        .reset      (rst_n),
        .EvictValid (evictValid),
        .EvictReady (evictReady),
        .EvictAdr   (evictAdr),
        .EvictLine  (evictLine),
        .EvictWay   (evictWay),
        .BusValid   (busValid),
        .BusReady   (busReady),
        .BusAdr     (busAdr),
        .BusData    (busData),
        .BusLast    (busLast),
        .Busy       (busy),
        .DrainWay   (drainWay),
        .SnoopAdr   (snoopAdr),
        .SnoopHit   (snoopHit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare accepted beats against the scoreboard, queue beats of each accepted line.
    always @(negedge clk) begin
        if (rst_n && busValid && busReady) begin
            beatsSeen++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got adr %0h with nothing expected", busAdr);
            end else begin
                beat_t e;
                e = sbq.pop_front();
                chk("sb_adr", {8'h00, busAdr}, {8'h00, e.adr});
                chk("sb_data", busData, e.data);
                chk("sb_last", {63'd0, busLast}, {63'd0, e.last});
                chk("sb_way", {60'd0, drainWay}, {60'd0, e.way});
            end
        end
        if (rst_n && evictValid && evictReady) begin
            for (int k = 0; k < 4; k++) begin
                beat_t b;
                b.adr  = {evictAdr[55:5], 5'd0} + 56'(k * 8);
                b.data = evictLine[k*64 +: 64];
                b.last = (k == 3);
                b.way  = evictWay;
                sbq.push_back(b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        evictValid = 1'b0;
        evictAdr   = ADR_A;
        evictLine  = LINE_A;
        evictWay   = 4'b0100;
        busReady   = 1'b1;
        snoopAdr   = 56'd0;

        //        ev    br    snoop            er    bv    bl    bsy   badr             bdata              dway     sh
        tbl[0] = '{1'b1, 1'b1, 56'h80001234, 1'b1, 1'b0, 1'b0, 1'b0, 56'h0,         64'h0,             4'b0000, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 56'h8000123F, 1'b0, 1'b1, 1'b0, 1'b1, 56'h80001220, {16{4'h1}},        4'b0100, SNOOP_EN};
        tbl[2] = '{1'b0, 1'b1, 56'h80001240, 1'b0, 1'b1, 1'b0, 1'b1, 56'h80001228, {16{4'h2}},        4'b0100, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 56'h0,        1'b0, 1'b1, 1'b0, 1'b1, 56'h80001230, {16{4'h3}},        4'b0100, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 56'h80001220, 1'b0, 1'b1, 1'b1, 1'b1, 56'h80001238, {16{4'h4}},        4'b0100, SNOOP_EN};
        tbl[5] = '{1'b0, 1'b1, 56'h80001220, 1'b1, 1'b0, 1'b0, 1'b0, 56'h0,         64'h0,             4'b0000, 1'b0};

        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();

        // Basic drain with snoop probes
        for (int i = 0; i < 6; i++) begin
            evictValid = tbl[i].ev;
            busReady   = tbl[i].br;
            snoopAdr   = tbl[i].snoop;
            @(negedge clk);
            chk("evict_ready", {63'd0, evictReady}, {63'd0, tbl[i].er});
            chk("bus_valid", {63'd0, busValid}, {63'd0, tbl[i].bv});
            chk("bus_last", {63'd0, busLast}, {63'd0, tbl[i].bl});
            chk("busy", {63'd0, busy}, {63'd0, tbl[i].bsy});
            chk("bus_adr", {8'h00, busAdr}, {8'h00, tbl[i].badr});
            chk("bus_data", busData, tbl[i].bdata);
            chk("drain_way", {60'd0, drainWay}, {60'd0, tbl[i].dway});
            chk("snoop_hit", {63'd0, snoopHit}, {63'd0, tbl[i].sh});
            tick();
        end

        // Backpressure on beat 1 for three cycles
        evictValid = 1'b1;
        busReady   = 1'b1;
        tick();
        evictValid = 1'b0;
        tick();
        busReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", {63'd0, busValid}, 64'd1);
            chk("stall_adr", {8'h00, busAdr}, {8'h00, 56'h80001228});
            chk("stall_data", busData, {16{4'h2}});
            tick();
        end
        busReady = 1'b1;
        repeat (4) tick();

        // Second offer held during a drain is taken only after the last beat
        evictValid = 1'b1;
        tick();
        evictAdr  = ADR_B;
        evictLine = LINE_B;
        evictWay  = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_not_ready", {63'd0, evictReady}, 64'd0);
            tick();
        end
        @(negedge clk);
        chk("b2b_ready_gap", {63'd0, evictReady}, 64'd1);
        chk("b2b_idle_gap", {63'd0, busValid}, 64'd0);
        tick();
        evictValid = 1'b0;
        @(negedge clk);
        chk("b2b_second_valid", {63'd0, busValid}, 64'd1);
        chk("b2b_second_adr", {8'h00, busAdr}, {8'h00, 56'h0000_00C0_FFE0});
        chk("b2b_second_way", {60'd0, drainWay}, {60'd0, 4'b0001});
        tick();
        repeat (4) tick();
        evictAdr  = ADR_A;
        evictLine = LINE_A;
        evictWay  = 4'b0100;

        // Reset in the middle of a drain
        evictValid = 1'b1;
        tick();
        evictValid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_bus_valid", {63'd0, busValid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_drain_way", {60'd0, drainWay}, 64'd0);
        sbq.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {63'd0, evictReady}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            chk("post_rst_no_beat", {63'd0, busValid}, 64'd0);
        end

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        chk("beats_total", 64'(beatsSeen), 64'd18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
